// File: rtl/seq_accumulator_pkg.sv
// Shared types and constants for the sequential signed accumulator.
package seq_accumulator_pkg;

  localparam int unsigned DATA_W = 8;

  localparam logic [DATA_W-1:0] SAT_POS = 8'h7F;
  localparam logic [DATA_W-1:0] SAT_NEG = 8'h80;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Clamp value chosen by the sign shared by both operands of an overflowing add.
  function automatic logic [DATA_W-1:0] sat_value(input logic neg);
    return neg ? SAT_NEG : SAT_POS;
  endfunction

endpackage

// File: rtl/seq_accumulator_add8.sv
// 8-bit two's-complement adder with signed-overflow detect; carry out is dropped.
module acc_add8
  import seq_accumulator_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] s,
  output logic              overflow
);

  assign s        = a + b;
  assign overflow = (a[DATA_W-1] == b[DATA_W-1]) && (s[DATA_W-1] != a[DATA_W-1]);

endmodule

// File: rtl/seq_accumulator.sv
// Accumulates a job of `count` signed 8-bit operands and presents the sum with a sticky overflow flag.
module seq_accumulator
  import seq_accumulator_pkg::*;
#(
  parameter int unsigned SATURATE = 0,
  parameter int unsigned CNT_W    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  count,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_sum,
  output logic              out_ovf,
  input  logic              out_ready,
  output logic              busy
);

  state_e             state_q, state_d;
  logic [DATA_W-1:0]  acc_q, acc_d;
  logic               ovf_q, ovf_d;
  logic [CNT_W-1:0]   rem_q, rem_d;
  logic               in_ready_q, out_valid_q, busy_q;

  logic [DATA_W-1:0]  add_s;
  logic               add_ovf;

  acc_add8 u_add (
    .a        (acc_q),
    .b        (in_data),
    .s        (add_s),
    .overflow (add_ovf)
  );

  // Next-state, accumulator and counter update.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    rem_d   = rem_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d = '0;
          ovf_d = 1'b0;
          if (count != '0) begin
            rem_d   = count;
            state_d = ACC;
          end else begin
            state_d = DONE;
          end
        end
      end
      ACC: begin
        if (in_valid) begin
          if ((SATURATE != 0) && add_ovf) begin
            acc_d = sat_value(in_data[DATA_W-1]);
          end else begin
            acc_d = add_s;
          end
          ovf_d = ovf_q | add_ovf;
          rem_d = rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1)) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake flags are registered from the next state so they align with state_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      rem_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      rem_q       <= rem_d;
      in_ready_q  <= (state_d == ACC);
      out_valid_q <= (state_d == DONE);
      busy_q      <= (state_d != IDLE);
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign out_sum   = acc_q;
  assign out_ovf   = ovf_q;

endmodule
